// File: rtl/cmp_share_arbiter_pkg.sv
// Shared constants for the two-requester comparator arbiter.
package cmp_share_arbiter_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/cmp_share_arbiter_if.sv
// Request/result bundle between two compare clients and the shared arbiter.
interface cmp_share_arbiter_if #(
  parameter int unsigned n = cmp_share_arbiter_pkg::N_DEFAULT
) ();

  logic         req0;
  logic [n-1:0] a0;
  logic [n-1:0] b0;
  logic         req1;
  logic [n-1:0] a1;
  logic [n-1:0] b1;
  logic         ack0;
  logic         ack1;
  logic         lt;
  logic         gt;
  logic         eq;
  logic         gnt_id;
  logic         busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  ack0, ack1, lt, gt, eq, gnt_id, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output ack0, ack1, lt, gt, eq, gnt_id, busy
  );

endinterface

// File: rtl/cmp_share_arbiter_comparator.sv
// Existing combinational unsigned magnitude comparator.
module comparator #(
  parameter int unsigned n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         i,
  output logic         j,
  output logic         k
);

  assign i = (a < b);
  assign j = (a > b);
  assign k = (a == b);

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter sharing one comparator between two requesters;
// latches the winner's operands, registers the result and pulses its ack.
module cmp_share_arbiter
  import cmp_share_arbiter_pkg::*;
#(
  parameter int unsigned n = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_share_arbiter_if.slave  bus
);

  state_e       state_q, state_d;
  logic [n-1:0] op_a_q, op_a_d;
  logic [n-1:0] op_b_q, op_b_d;
  logic         last_gnt_q, last_gnt_d;
  logic         gnt_id_q, gnt_id_d;
  logic         ack0_q, ack0_d;
  logic         ack1_q, ack1_d;
  logic         lt_q, lt_d;
  logic         gt_q, gt_d;
  logic         eq_q, eq_d;
  logic         busy_q, busy_d;
  logic         win_c;
  logic         cmp_lt_c, cmp_gt_c, cmp_eq_c;

  comparator #(.n(n)) u_cmp (
    .a (op_a_q),
    .b (op_b_q),
    .i (cmp_lt_c),
    .j (cmp_gt_c),
    .k (cmp_eq_c)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    last_gnt_d = last_gnt_q;
    gnt_id_d   = gnt_id_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    lt_d       = lt_q;
    gt_d       = gt_q;
    eq_d       = eq_q;
    win_c      = REQ0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // On a tie the requester not served last time wins
          if (bus.req0 && bus.req1) win_c = ~last_gnt_q;
          else                      win_c = bus.req1 ? REQ1 : REQ0;
          op_a_d     = (win_c == REQ1) ? bus.a1 : bus.a0;
          op_b_d     = (win_c == REQ1) ? bus.b1 : bus.b0;
          gnt_id_d   = win_c;
          last_gnt_d = win_c;
          state_d    = CMP;
        end
      end
      CMP: begin
        lt_d    = cmp_lt_c;
        gt_d    = cmp_gt_c;
        eq_d    = cmp_eq_c;
        ack0_d  = (gnt_id_q == REQ0);
        ack1_d  = (gnt_id_q == REQ1);
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      last_gnt_q <= REQ1;
      gnt_id_q   <= REQ0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      lt_q       <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      last_gnt_q <= last_gnt_d;
      gnt_id_q   <= gnt_id_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
      lt_q       <= lt_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ack0   = ack0_q;
  assign bus.ack1   = ack1_q;
  assign bus.lt     = lt_q;
  assign bus.gt     = gt_q;
  assign bus.eq     = eq_q;
  assign bus.gnt_id = gnt_id_q;
  assign bus.busy   = busy_q;

endmodule
